mem_access_unit: RTL

- Sits between the CPU memory stage and the word-wide, big-endian data memory (DATA_MEM_SIZE = 128 bytes).
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Aligns each request to the word address and performs read-modify-write for sub-word stores.
- Sign- or zero-extends load results and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU memory stage and a word-wide, big-endian data memory.
// Handles byte/half/word accesses, sub-word read-modify-write, load extension and access errors.
module mem_access_unit #(
    parameter int MEM_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_write,
    output logic        dm_mem_read,
    input  logic [31:0] dm_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

    state_t      state_reg, state_next;
    logic        write_reg, unsigned_reg, err_reg;
    logic [1:0]  size_reg, offset_reg;
    logic [31:0] wdata_reg, word_reg, addr_out_reg, wdata_out_reg;

    logic        accept;
    logic [2:0]  req_bytes;
    logic [32:0] req_end;
    logic        req_err;
    logic [31:0] merged_word;
    logic [31:0] load_data;

    assign accept = req_valid && req_ready;

    // 33-bit end address so a request near 2^32 cannot wrap into range
    always_comb begin
        case (req_size)
            2'd0:    req_bytes = 3'd1;
            2'd1:    req_bytes = 3'd2;
            default: req_bytes = 3'd4;
        endcase
        req_end = {1'b0, req_addr} + {30'b0, req_bytes};
        req_err = (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'b00)
               || (req_end > 33'(MEM_SIZE));
    end

    // Big-endian lanes: offset 0 is the most significant byte
    always_comb begin
        case (size_reg)
            2'd0: begin
                case (offset_reg)
                    2'd0:    merged_word = {wdata_reg[7:0], word_reg[23:0]};
                    2'd1:    merged_word = {word_reg[31:24], wdata_reg[7:0], word_reg[15:0]};
                    2'd2:    merged_word = {word_reg[31:16], wdata_reg[7:0], word_reg[7:0]};
                    default: merged_word = {word_reg[31:8], wdata_reg[7:0]};
                endcase
            end
            2'd1:    merged_word = offset_reg[1] ? {word_reg[31:16], wdata_reg[15:0]}
                                                 : {wdata_reg[15:0], word_reg[15:0]};
            default: merged_word = wdata_reg;
        endcase
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        case (offset_reg)
            2'd0:    lane_b = word_reg[31:24];
            2'd1:    lane_b = word_reg[23:16];
            2'd2:    lane_b = word_reg[15:8];
            default: lane_b = word_reg[7:0];
        endcase
        lane_h = offset_reg[1] ? word_reg[15:0] : word_reg[31:16];
        case (size_reg)
            2'd0:    load_data = {{24{lane_b[7] & ~unsigned_reg}}, lane_b};
            2'd1:    load_data = {{16{lane_h[15] & ~unsigned_reg}}, lane_h};
            default: load_data = word_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            unsigned_reg  <= 1'b0;
            err_reg       <= 1'b0;
            size_reg      <= 2'd0;
            offset_reg    <= 2'd0;
            wdata_reg     <= 32'd0;
            word_reg      <= 32'd0;
            addr_out_reg  <= 32'd0;
            wdata_out_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            wdata_out_reg <= dm_write_data;
            if (accept) begin
                write_reg    <= req_write;
                unsigned_reg <= req_unsigned;
                err_reg      <= req_err;
                size_reg     <= req_size;
                offset_reg   <= req_addr[1:0];
                wdata_reg    <= req_wdata;
                // Errored requests never reach memory, so the address bus keeps its last value
                if (!req_err) begin
                    addr_out_reg <= {req_addr[31:2], 2'b00};
                end
            end
            if (state_reg == ACCESS && dm_mem_read) begin
                word_reg <= dm_read_data;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;
        dm_write_data = wdata_out_reg;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (write_reg && size_reg == 2'd2) begin
                    dm_mem_write  = 1'b1;
                    dm_write_data = wdata_reg;
                    state_next    = RESP;
                end else begin
                    dm_mem_read = 1'b1;
                    state_next  = write_reg ? MERGE : RESP;
                end
            end
            MERGE: begin
                dm_mem_write  = 1'b1;
                dm_write_data = merged_word;
                state_next    = RESP;
            end
            default: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign dm_addr    = addr_out_reg;
    assign resp_err   = resp_valid && err_reg;
    assign resp_rdata = (resp_valid && !err_reg && !write_reg) ? load_data : 32'd0;

endmodule
